dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares one single-port BRAM port A (1-cycle read latency, 4-bit byte WE) between two requesters:
//  m0 = CPU data port, m1 = loader/debug port. Per-cycle arbitration, optional lock for atomic
//  multi-cycle sequences, registered read-return tagging. Sits in top between cpu and data_memory.
// PARAMETERS
//  DATA_W      32  data width of requesters and memory
//  ADDR_W      32  requester byte-address width
//  WE_W         4  byte write-enable width (DATA_W/8)
//  MEM_ADDR_W  10  BRAM word-address width
// PORTS
//  clk          in   1           single clock, all state on rising edge
//  reset        in   1           asynchronous, active-low reset
//  mN_req       in   1           N=0,1: access request, held until mN_gnt
//  mN_lock      in   1           keep ownership after this grant
//  mN_we        in   WE_W        byte WE; all-zero = read
//  mN_addr      in   ADDR_W      byte address
//  mN_wdata     in   DATA_W      write data
//  mN_gnt       out  1           access accepted this cycle (combinational)
//  mN_rvalid    out  1           read data valid (registered)
//  mN_rdata     out  DATA_W      = mem_rdata_i, qualified by mN_rvalid
//  mem_we_o     out  WE_W        BRAM byte WE
//  mem_addr_o   out  MEM_ADDR_W  BRAM word address = winner addr[MEM_ADDR_W+1:2]
//  mem_wdata_o  out  DATA_W      BRAM write data
//  mem_rdata_i  in   DATA_W      BRAM read data, valid 1 cycle after address
// BEHAVIOUR
//  - FSM states ARB, LOCK0, LOCK1. reset low: state=ARB, rr_ptr=0, rvalid regs=0; mN_gnt=0,
//    mem_we_o=0 while reset low; mem_addr_o/mem_wdata_o follow m0 (don't-care).
//  - ARB: winner per priority rule among asserted mN_req; only winner gets gnt; at most one gnt/cycle.
//    Winner with mN_lock=1 -> next state LOCKN; else stay ARB. No req -> mem_we_o=0, addr from m0.
//  - LOCKN: only mN may be granted (gnt=mN_req); other requester stalls regardless of priority.
//    Next state ARB when mN_lock=0 sampled at edge, else stay LOCKN. Lock without req holds ownership.
//  - Mem drive: granted requester's we/addr/wdata muxed combinationally to mem_*; ungranted -> we=0.
//  - Read return: granted read (we==0) sets mN_rvalid on next cycle for exactly 1 cycle; writes
//    never produce rvalid. Back-to-back reads: 1 per cycle, rvalid pipelined, no bubbles.
//  - Addr bits [1:0] and above MEM_ADDR_W+1 ignored (no fault). Byte lanes per mN_we bit.
//  - Reset mid-operation: lock released, in-flight read dropped (no rvalid after reset release).
//  - Requester obligation: req/we/addr/wdata stable until gnt; arbiter does not buffer requests.
// CONFIGURATION
//  DMEM_ARB_ROUND_ROBIN_EN defined: in ARB, on contention winner = rr_ptr; after any ARB grant
//    rr_ptr <= ~winner (grants in LOCK state don't move rr_ptr). rr_ptr=0 after reset.
//  Not defined: fixed priority m0 > m1; rr_ptr logic absent; m1 may starve under continuous m0 req.
// STRUCTURE
//  Package dmem_arb_pkg: state encodings ST_ARB/ST_LOCK0/ST_LOCK1, requester IDs REQ_M0/REQ_M1.
//  Sub-module dmem_arb_pick: combinational 2-way picker (req0, req1, rr_ptr -> one-hot grant);
//  FSM, muxes and rvalid pipeline stay in dmem_arbiter.
// TESTING
//  1 m0 write we=4'hF addr=0x10 data=0xDEADBEEF, then m0 read 0x10 -> m0_gnt same cycle,
//    mem_addr_o=4, m0_rvalid next cycle with rdata 0xDEADBEEF, m1_rvalid=0.
//  2 Both req every cycle, macro off -> m0_gnt every cycle, m1_gnt=0; macro on -> gnt alternates
//    m0,m1,m0,... starting m0 after reset.
//  3 m1 req+lock for 3 cycles while m0 req -> m1 gnt 3 cycles, m0 stalled; m1 lock low -> m0 gnt next.
//  4 Partial write we=4'b0010 data=0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
//  5 reset low the cycle after a granted m0 read -> no m0_rvalid after release, state ARB, gnt=0 in reset.
//  6 m0 reads 0x0,0x4,0x8 back-to-back -> 3 consecutive rvalid cycles, data in address order.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter between the CPU
// data port (m0) and the loader/debug port (m1).
package dmem_arb_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 32;
  localparam int WE_W_DEF       = 4;
  localparam int MEM_ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_e;

  // Next round-robin pointer: the loser of this grant goes first next time.
  function automatic req_id_e other_req(input req_id_e winner);
    return (winner == REQ_M0) ? REQ_M1 : REQ_M0;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational 2-way picker: one-hot grant from two requests, with rr_ptr
// choosing the winner on contention (tie it to REQ_M0 for fixed priority).
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  req_id_e    rr_ptr,
  output logic [1:0] gnt
);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = (rr_ptr == REQ_M1) ? 2'b10 : 2'b01;
    end else begin
      gnt = {req1, req0};
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port BRAM with lock support and registered
// read-valid tagging. Define DMEM_ARB_ROUND_ROBIN_EN for round-robin on contention.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WE_W       = WE_W_DEF,
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic [WE_W-1:0]       m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic [WE_W-1:0]       m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [WE_W-1:0]       mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  arb_state_e state;
  req_id_e    rr_ptr;
  logic [1:0] pick_gnt;

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  assign rr_ptr = REQ_M0;
`endif

  dmem_arb_pick u_pick (
    .req0   (m0_req),
    .req1   (m1_req),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt)
  );

  // Grants are combinational so a requester is accepted in the cycle it asks.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    unique case (state)
      ST_ARB:   {m1_gnt, m0_gnt} = pick_gnt;
      ST_LOCK0: m0_gnt = m0_req;
      ST_LOCK1: m1_gnt = m1_req;
      default:  ;
    endcase
    if (!reset) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end
  end

  always_comb begin
    if (m1_gnt) begin
      mem_we_o    = m1_we;
      mem_addr_o  = m1_addr[MEM_ADDR_W+1:2];
      mem_wdata_o = m1_wdata;
    end else begin
      mem_we_o    = m0_gnt ? m0_we : '0;
      mem_addr_o  = m0_addr[MEM_ADDR_W+1:2];
      mem_wdata_o = m0_wdata;
    end
  end

  // Byte offset and bits above the BRAM window are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[1:0], m0_addr[ADDR_W-1:MEM_ADDR_W+2],
                              m1_addr[1:0], m1_addr[ADDR_W-1:MEM_ADDR_W+2]};

  assign m0_rdata = mem_rdata_i;
  assign m1_rdata = mem_rdata_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_ARB;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      rr_ptr    <= REQ_M0;
`endif
    end else begin
      m0_rvalid <= m0_gnt && (m0_we == '0);
      m1_rvalid <= m1_gnt && (m1_we == '0);
      unique case (state)
        ST_ARB: begin
          if (m0_gnt && m0_lock)      state <= ST_LOCK0;
          else if (m1_gnt && m1_lock) state <= ST_LOCK1;
        end
        ST_LOCK0: if (!m0_lock) state <= ST_ARB;
        ST_LOCK1: if (!m1_lock) state <= ST_ARB;
        default:  state <= ST_ARB;
      endcase
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      if (state == ST_ARB && (m0_gnt || m1_gnt)) begin
        rr_ptr <= other_req(m0_gnt ? REQ_M0 : REQ_M1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency byte-WE BRAM.
// Expected values are hand-computed; round-robin expectations follow DMEM_ARB_ROUND_ROBIN_EN.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;

  logic [31:0] mem [0:1023];
  int n_pass  = 0;
  int n_total = 0;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
    mem_rdata_i <= mem[mem_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_m0(input logic req, input logic lock, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_lock = lock; m0_we = we; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic lock, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_lock = lock; m1_we = we; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic idle();
    drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic exp_g0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem_rdata_i = 32'h0;
    idle();
    reset = 1'b0;
    drive_m0(1'b1, 1'b0, 4'hF, 32'h10, 32'h5555_5555);
    drive_m1(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    repeat (2) tick();
    mid();
    check("rst_gnt0", m0_gnt, 0);
    check("rst_gnt1", m1_gnt, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_rvalid0", m0_rvalid, 0);
    idle();
    reset = 1'b1;
    tick();

    // m0 full write then read-back of the same word
    drive_m0(1'b1, 1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF);
    mid();
    check("t1_wr_gnt0", m0_gnt, 1);
    check("t1_wr_gnt1", m1_gnt, 0);
    check("t1_wr_addr", mem_addr_o, 4);
    check("t1_wr_we", mem_we_o, 4'hF);
    check("t1_wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    tick();
    check("t1_wr_no_rvalid", m0_rvalid, 0);
    drive_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    mid();
    check("t1_rd_gnt0", m0_gnt, 1);
    check("t1_rd_addr", mem_addr_o, 4);
    check("t1_rd_we", mem_we_o, 0);
    tick();
    idle();
    check("t1_rvalid0", m0_rvalid, 1);
    check("t1_rdata0", m0_rdata, 32'hDEAD_BEEF);
    check("t1_rvalid1", m1_rvalid, 0);
    tick();
    check("t1_rvalid_1cyc", m0_rvalid, 0);

    // partial byte write, read back through an address with ignored bits set
    drive_m0(1'b1, 1'b0, 4'hF, 32'h14, 32'h1122_3344);
    tick();
    drive_m0(1'b1, 1'b0, 4'b0010, 32'h14, 32'h0000_AB00);
    mid();
    check("t4_pw_we", mem_we_o, 4'b0010);
    tick();
    drive_m0(1'b1, 1'b0, 4'h0, 32'hFFFF_F017, 32'h0);
    mid();
    check("t4_rd_addr_wrap", mem_addr_o, 5);
    tick();
    idle();
    check("t4_rvalid", m0_rvalid, 1);
    check("t4_rdata", m0_rdata, 32'h1122_AB44);

    // m1 loads three words (no rvalid for writes), then m0 reads them back-to-back
    drive_m1(1'b1, 1'b0, 4'hF, 32'h0, 32'h0000_00A0);
    mid(); check("t6_w0_gnt1", m1_gnt, 1); tick();
    drive_m1(1'b1, 1'b0, 4'hF, 32'h4, 32'h0000_00A4);
    mid(); check("t6_w1_gnt1", m1_gnt, 1); tick();
    drive_m1(1'b1, 1'b0, 4'hF, 32'h8, 32'h0000_00A8);
    mid(); check("t6_w2_gnt1", m1_gnt, 1); tick();
    idle();
    check("t6_wr_no_rvalid1", m1_rvalid, 0);
    drive_m0(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    drive_m0(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    check("t6_rv0", m0_rvalid, 1);
    check("t6_rd0", m0_rdata, 32'h0000_00A0);
    tick();
    drive_m0(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    check("t6_rv1", m0_rvalid, 1);
    check("t6_rd1", m0_rdata, 32'h0000_00A4);
    tick();
    idle();
    check("t6_rv2", m0_rvalid, 1);
    check("t6_rd2", m0_rdata, 32'h0000_00A8);
    tick();
    check("t6_rv_end", m0_rvalid, 0);

    // contention from a fresh reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive_m0(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_m1(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp_g0 = ((i % 2) == 0);
`else
      exp_g0 = 1'b1;
`endif
      mid();
      check($sformatf("t2_gnt0_c%0d", i), m0_gnt, exp_g0);
      check($sformatf("t2_gnt1_c%0d", i), m1_gnt, !exp_g0);
      tick();
      check($sformatf("t2_rv1_c%0d", i), m1_rvalid, !exp_g0);
    end
    idle();

    // m1 lock sequence with m0 stalled; lock without req keeps ownership
    drive_m1(1'b1, 1'b1, 4'hF, 32'h20, 32'h0000_0020);
    mid(); check("t3_c1_gnt1", m1_gnt, 1); check("t3_c1_gnt0", m0_gnt, 0); tick();
    drive_m0(1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
    mid(); check("t3_c2_gnt1", m1_gnt, 1); check("t3_c2_gnt0", m0_gnt, 0); tick();
    drive_m1(1'b0, 1'b1, 4'hF, 32'h20, 32'h0000_0020);
    mid(); check("t3_c3_gnt1", m1_gnt, 0); check("t3_c3_gnt0", m0_gnt, 0); tick();
    drive_m1(1'b1, 1'b0, 4'hF, 32'h20, 32'h0000_0020);
    mid(); check("t3_c4_gnt1", m1_gnt, 1); check("t3_c4_gnt0", m0_gnt, 0); tick();
    check("t3_stall_no_rv0", m0_rvalid, 0);
    drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mid(); check("t3_c5_gnt0", m0_gnt, 1); check("t3_c5_gnt1", m1_gnt, 0); tick();
    idle();
    check("t3_c5_rv0", m0_rvalid, 1);

    // reset the cycle after a granted, locking m0 read
    drive_m0(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);
    mid(); check("t5_gnt0", m0_gnt, 1); tick();
    reset = 1'b0;
    drive_m0(1'b1, 1'b0, 4'hF, 32'h10, 32'hFFFF_FFFF);
    mid();
    check("t5_rst_gnt0", m0_gnt, 0);
    check("t5_rst_mem_we", mem_we_o, 0);
    check("t5_rst_rv0", m0_rvalid, 0);
    tick();
    reset = 1'b1;
    idle();
    drive_m1(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    check("t5_rel_rv0", m0_rvalid, 0);
    mid();
    check("t5_rel_gnt1", m1_gnt, 1);
    tick();
    idle();
    check("t5_after_rv0", m0_rvalid, 0);
    check("t5_after_rv1", m1_rvalid, 1);
    check("t5_after_rd1", m1_rdata, 32'hDEAD_BEEF);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
